// File: rtl/capture_session_if.sv
// Host/FIFO-side signal bundle for capture_session_ctrl.
// master drives commands and FIFO status; slave is the sequencer.
interface capture_session_if #(
  parameter int REV_BITS = 8
);
  logic                cmd_start;
  logic                cmd_abort;
  logic [REV_BITS-1:0] cfg_revs;
  logic [31:0]         cfg_index_timeout;
  logic                index_pulse;
  logic                fifo_overflow;
  logic                fifo_empty;
  logic                stats_clear;
  logic                capture_active;
  logic                busy;
  logic                done;
  logic [2:0]          status;
  logic [REV_BITS-1:0] rev_count;
  logic [2:0]          state;

  modport master (
    output cmd_start, cmd_abort, cfg_revs, cfg_index_timeout,
           index_pulse, fifo_overflow, fifo_empty,
    input  stats_clear, capture_active, busy, done, status, rev_count, state
  );

  modport slave (
    input  cmd_start, cmd_abort, cfg_revs, cfg_index_timeout,
           index_pulse, fifo_overflow, fifo_empty,
    output stats_clear, capture_active, busy, done, status, rev_count, state
  );
endinterface

// File: rtl/capture_session_ctrl.sv
// Flux-capture session sequencer: clear stats, arm on index, capture N revs, drain, report.
// Define CAPTURE_CTRL_OVF_ABORT_EN to make FIFO overflow end the session early.
module capture_session_ctrl #(
  parameter int REV_BITS     = 8,
  parameter int DRAIN_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  capture_session_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ARM     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0]  ST_OK     = 3'd0;
  localparam logic [2:0]  ST_ABORT  = 3'd1;
  localparam logic [2:0]  ST_NOIDX  = 3'd2;
  localparam logic [2:0]  ST_OVF    = 3'd3;
  localparam logic [2:0]  ST_DTO    = 3'd4;
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

`ifdef CAPTURE_CTRL_OVF_ABORT_EN
  localparam bit OVF_ABORT = 1'b1;
`else
  localparam bit OVF_ABORT = 1'b0;
`endif

  state_t              r_state, w_state_nxt;
  logic                r_idx_prev;
  logic [31:0]         r_timer, w_timer_nxt;
  logic [REV_BITS-1:0] r_rev_count, w_rev_nxt;
  logic [REV_BITS-1:0] r_cfg_revs, w_cfg_revs_nxt;
  logic [31:0]         r_cfg_to, w_cfg_to_nxt;
  logic [2:0]          r_status, w_status_nxt;
  logic                r_ovf_seen, w_ovf_nxt;

  logic                w_idx_edge;
  logic [31:0]         w_timer_inc;
  logic [REV_BITS-1:0] w_rev_inc;
  logic [REV_BITS-1:0] w_rev_sat;
  logic                w_rev_done;

  assign w_idx_edge  = bus.index_pulse & ~r_idx_prev;
  assign w_timer_inc = r_timer + 32'd1;
  assign w_rev_inc   = r_rev_count + REV_BITS'(1);
  assign w_rev_sat   = (&r_rev_count) ? r_rev_count : w_rev_inc;
  // A saturated counter wraps w_rev_inc to 0, which never matches a nonzero target.
  assign w_rev_done  = (r_cfg_revs != '0) && (w_rev_inc == r_cfg_revs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx_prev  <= 1'b0;
      r_timer     <= '0;
      r_rev_count <= '0;
      r_cfg_revs  <= '0;
      r_cfg_to    <= '0;
      r_status    <= ST_OK;
      r_ovf_seen  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx_prev  <= bus.index_pulse;
      r_timer     <= w_timer_nxt;
      r_rev_count <= w_rev_nxt;
      r_cfg_revs  <= w_cfg_revs_nxt;
      r_cfg_to    <= w_cfg_to_nxt;
      r_status    <= w_status_nxt;
      r_ovf_seen  <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_rev_nxt      = r_rev_count;
    w_cfg_revs_nxt = r_cfg_revs;
    w_cfg_to_nxt   = r_cfg_to;
    w_status_nxt   = r_status;
    w_ovf_nxt      = r_ovf_seen;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_start) begin
          w_cfg_revs_nxt = bus.cfg_revs;
          w_cfg_to_nxt   = bus.cfg_index_timeout;
          w_rev_nxt      = '0;
          w_timer_nxt    = '0;
          w_status_nxt   = ST_OK;
          w_ovf_nxt      = 1'b0;
          w_state_nxt    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (bus.cmd_abort) begin
          w_status_nxt = ST_ABORT;
          w_state_nxt  = S_DONE;
        end else begin
          w_state_nxt  = S_ARM;
        end
      end
      S_ARM: begin
        // Compare the incremented value so ARM lasts exactly cfg_index_timeout cycles.
        w_timer_nxt = w_timer_inc;
        if (bus.cmd_abort) begin
          w_status_nxt = ST_ABORT;
          w_state_nxt  = S_DONE;
        end else if (OVF_ABORT && bus.fifo_overflow) begin
          w_status_nxt = ST_OVF;
          w_state_nxt  = S_DONE;
        end else if (w_idx_edge) begin
          w_timer_nxt  = '0;
          w_state_nxt  = S_CAPTURE;
        end else if ((r_cfg_to != 32'd0) && (w_timer_inc == r_cfg_to)) begin
          w_status_nxt = ST_NOIDX;
          w_state_nxt  = S_DONE;
        end
      end
      S_CAPTURE: begin
        w_ovf_nxt = r_ovf_seen | bus.fifo_overflow;
        if (bus.cmd_abort) begin
          w_status_nxt = ST_ABORT;
          w_timer_nxt  = '0;
          w_state_nxt  = S_DRAIN;
        end else if (OVF_ABORT && bus.fifo_overflow) begin
          w_status_nxt = ST_OVF;
          w_timer_nxt  = '0;
          w_state_nxt  = S_DRAIN;
        end else if (w_idx_edge) begin
          w_rev_nxt = w_rev_sat;
          if (w_rev_done) begin
            w_status_nxt = (r_ovf_seen | bus.fifo_overflow) ? ST_OVF : ST_OK;
            w_timer_nxt  = '0;
            w_state_nxt  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (bus.cmd_abort) begin
          w_status_nxt = ST_ABORT;
          w_state_nxt  = S_DONE;
        end else if (bus.fifo_empty) begin
          w_state_nxt  = S_DONE;
        end else if (r_timer == DRAIN_LAST) begin
          if (r_status == ST_OK) w_status_nxt = ST_DTO;
          w_state_nxt  = S_DONE;
        end else begin
          w_timer_nxt  = w_timer_inc;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.stats_clear    = (r_state == S_CLEAR);
  assign bus.capture_active = (r_state == S_CAPTURE);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = (r_state == S_DONE);
  assign bus.status         = r_status;
  assign bus.rev_count      = r_rev_count;
  assign bus.state          = r_state;

endmodule

// File: tb/tb_capture_session_ctrl.sv
// Directed + randomized sessions against an event-time model of capture_session_ctrl.
module tb_capture_session_ctrl;
  localparam int RB = 8;
  localparam int DC = 256;

  logic clk = 1'b0;
  logic reset_n;

  capture_session_if #(.REV_BITS(RB)) bus ();

  capture_session_ctrl #(.REV_BITS(RB), .DRAIN_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // stimulus schedule, expressed as absolute cycle numbers
  int g_start = -1, g_start2 = -1, g_idx_base = -1, g_P = 1;
  int g_abort = -1, g_ovf = -1, g_empty = -1;
  int g_revs = 0, g_revs2 = 0, g_to = 0;

  // observations
  int n_clr, clr_cyc, n_cap, cap_first, n_done, done_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] rv;
    @(posedge clk);
    cyc++;
    #1;
    if (bus.stats_clear) begin n_clr++; clr_cyc = cyc; end
    if (bus.capture_active) begin if (n_cap == 0) cap_first = cyc; n_cap++; end
    if (bus.done) begin n_done++; done_cyc = cyc; end
    rv = (cyc == g_start2) ? g_revs2 : g_revs;
    bus.cmd_start         = (cyc == g_start) || (cyc == g_start2);
    bus.cfg_revs          = rv[RB-1:0];
    bus.cfg_index_timeout = g_to;
    bus.cmd_abort         = (cyc == g_abort);
    bus.index_pulse       = (g_idx_base >= 0) && (cyc >= g_idx_base) && (((cyc - g_idx_base) % g_P) < 2);
    bus.fifo_overflow     = (g_ovf >= 0) && (cyc >= g_ovf);
    bus.fifo_empty        = (g_empty >= 0) && (cyc >= g_empty);
  endtask

  task automatic clear_obs();
    n_clr = 0; clr_cyc = -1; n_cap = 0; cap_first = -1; n_done = 0; done_cyc = -1;
  endtask

  // Model: start in cycle s -> CLEAR s+1 -> ARM from s+2. First index edge e0 = ARM entry + off.
  // Revolution k ends at e0 + k*P; capture_active covers cycles e0+1 .. end.
  task automatic session(input string tag, input int revs, input int to, input int P,
                         input bit idx_en, input int off, input int abort_arm,
                         input int abort_rev, input int ovf_rev, input int ed, input bit busy_start);
    int s, arm0, e0, t, exp_done, exp_status, exp_rev, exp_cap;
    bit captured;
    s = cyc + 1; arm0 = s + 2; e0 = arm0 + off;
    g_revs = revs; g_revs2 = revs + 2; g_to = to; g_P = P; g_start = s; g_start2 = -1;
    g_idx_base = idx_en ? e0 : -1;
    g_abort = -1; g_ovf = -1; g_empty = -1;
    captured = 1'b0; exp_cap = 0; exp_rev = 0; exp_status = 0; exp_done = 0; t = 0;
    if (abort_arm >= 0) begin
      g_abort = arm0 + abort_arm; exp_done = g_abort + 1; exp_status = 1;
    end else if (idx_en && (to == 0 || off < to)) begin
      captured = 1'b1;
    end else begin
      exp_done = arm0 + to; exp_status = 2;
    end
    if (captured) begin
      t = e0 + revs * P; exp_rev = revs;
      if (abort_rev >= 0) begin
        t = e0 + abort_rev * P + P / 2; g_abort = t; exp_status = 1;
        exp_rev = (abort_rev > 255) ? 255 : abort_rev;
      end
      if (ovf_rev >= 0) begin
        g_ovf = e0 + ovf_rev * P + P / 2;
`ifdef CAPTURE_CTRL_OVF_ABORT_EN
        t = g_ovf; exp_rev = ovf_rev; exp_status = 3;
`else
        if (exp_status == 0) exp_status = 3;
`endif
      end
      exp_cap = t - e0;
      if (ed >= 0) begin
        g_empty = t + 1 + ed; exp_done = t + 2 + ed;
      end else begin
        exp_done = t + 1 + DC; if (exp_status == 0) exp_status = 4;
      end
      if (busy_start) g_start2 = e0 + P / 2;
    end
    clear_obs();
    while (cyc < exp_done + 2) tick();
    chk({tag, ".clr_pulses"}, n_clr, 1);
    chk({tag, ".clr_cycle"}, clr_cyc, s + 1);
    chk({tag, ".done_pulses"}, n_done, 1);
    chk({tag, ".done_cycle"}, done_cyc, exp_done);
    chk({tag, ".cap_cycles"}, n_cap, exp_cap);
    if (captured) chk({tag, ".cap_rise"}, cap_first, e0 + 1);
    chk({tag, ".status"}, bus.status, exp_status);
    chk({tag, ".rev_count"}, bus.rev_count, exp_rev);
    chk({tag, ".idle"}, bus.busy, 0);
    g_ovf = -1; g_empty = -1;
  endtask

  task automatic reset_mid();
    int s;
    s = cyc + 1;
    g_revs = 4; g_to = 0; g_P = 60; g_start = s; g_start2 = -1;
    g_idx_base = s + 7; g_abort = -1; g_ovf = -1; g_empty = -1;
    clear_obs();
    while (cyc < g_idx_base + 63) tick();
    chk("rst.pre_capture", bus.capture_active, 1);
    reset_n = 1'b0;
    #1;
    chk("rst.capture", bus.capture_active, 0);
    chk("rst.clear", bus.stats_clear, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.state", bus.state, 0);
    chk("rst.rev", bus.rev_count, 0);
    #1;
    reset_n = 1'b1;
    g_idx_base = -1;
    repeat (20) tick();
    chk("rst.no_done", n_done, 0);
    chk("rst.stays_idle", bus.state, 0);
  endtask

  initial begin
    int P, off, ed, to, revs;
    reset_n = 1'b0;
    bus.cmd_start = 0; bus.cmd_abort = 0; bus.cfg_revs = '0; bus.cfg_index_timeout = '0;
    bus.index_pulse = 0; bus.fifo_overflow = 0; bus.fifo_empty = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.state", bus.state, 0);
    chk("reset.busy", bus.busy, 0);
    chk("reset.clear", bus.stats_clear, 0);
    chk("reset.capture", bus.capture_active, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.status", bus.status, 0);
    chk("reset.rev", bus.rev_count, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    session("basic", 3, 0, 1000, 1, 17, -1, -1, -1, 20, 0);
    session("noidx", 2, 500, 100, 0, 0, -1, -1, -1, 5, 0);
    P = $urandom_range(50, 150);
    session("abort_cap", 0, 0, P, 1, $urandom_range(0, 40), -1, 5, -1, $urandom_range(0, 30), 0);
    P = $urandom_range(50, 150);
    session("ovf", 4, 0, P, 1, $urandom_range(0, 40), -1, -1, $urandom_range(1, 2), $urandom_range(0, 30), 0);
    P = $urandom_range(50, 150);
    session("drain_to", 2, 0, P, 1, $urandom_range(0, 40), -1, -1, -1, -1, 0);
    session("abort_arm", 3, 0, 100, 0, 0, $urandom_range(0, 20), -1, -1, 3, 0);
    session("sat", 0, 0, 20, 1, 3, -1, 260, -1, 2, 0);
    reset_mid();
    session("after_rst", 2, 0, 80, 1, 11, -1, -1, -1, 7, 1);
    for (int i = 0; i < 4; i++) begin
      P    = $urandom_range(20, 200);
      off  = $urandom_range(0, P - 1);
      ed   = $urandom_range(0, 40);
      revs = $urandom_range(1, 5);
      to   = $urandom_range(0, 1) ? 0 : $urandom_range(1, 300);
      session($sformatf("rnd%0d", i), revs, to, P, 1, off, -1, -1, -1, ed, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
